// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the 8-bit CPU datapath: fetches over a
// req/ack handshake, holds the instruction in IR and issues per-state strobes.
module cpu_sequencer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             run_i,
   input  logic             step_i,
   output logic             imem_req_o,
   input  logic             imem_ack_i,
   input  logic [7:0]       instr_i,
   output logic [7:0]       ir_o,
   output logic             pc_inc_o,
   output logic             pc_load_o,
   output logic             reg_write_o,
   output logic             mem_to_reg_o,
   output logic             alu_negate_o,
   output logic             imm_sel_o,
   output logic             pc_sel_o,
   output logic             reg_num_shift_o,
   output logic             dmem_req_o,
   output logic             dmem_we_o,
   input  logic             dmem_ack_i,
   output logic             halted_o,
   output logic             fault_o,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] retired_o
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_MEM    = 3'd4;
   localparam logic [2:0] ST_WB     = 3'd5;

   localparam logic [7:0] MEM_LAST = 8'(MEM_TIMEOUT - 1);

   logic [2:0]       state_reg, state_next;
   logic [7:0]       ir_reg, ir_next;
   logic [CNT_W-1:0] retired_reg, retired_next;
   logic             fault_reg, fault_next;
   logic             run_q_reg;
   logic             halt_reg, halt_next;
   logic             step_reg, step_next;
   logic [7:0]       mem_cnt_reg, mem_cnt_next;

   logic [1:0] mode;
   logic [1:0] op;
   logic       is_jump, is_load, is_store, is_arith;
   logic       is_add, is_sub, is_halt;
   logic       steer_en;
   logic       run_rise;
   logic       retire;
   logic [2:0] after_retire;

   assign mode     = ir_reg[7:6];
   assign op       = ir_reg[5:4];
   assign is_jump  = (mode == 2'b00);
   assign is_load  = (mode == 2'b01);
   assign is_store = (mode == 2'b10);
   assign is_arith = (mode == 2'b11);
   assign is_add   = is_arith && (op == 2'b01);
   assign is_sub   = is_arith && (op == 2'b10);
   assign is_halt  = is_jump && (ir_reg[5:0] == 6'd0);
   assign run_rise = run_i && !run_q_reg;

   // IR-derived steering is held stable from DECODE until the instruction ends.
   assign steer_en = (state_reg == ST_DECODE) || (state_reg == ST_EXEC) ||
                     (state_reg == ST_MEM)    || (state_reg == ST_WB);

   assign retire = ((state_reg == ST_EXEC) && (is_jump || is_arith)) ||
                   ((state_reg == ST_MEM) && is_store && dmem_ack_i) ||
                   (state_reg == ST_WB);

   // A halt jump always parks; a step-initiated instruction also parks.
   assign after_retire = (is_halt || !run_i || step_reg) ? ST_IDLE : ST_FETCH;

   always_comb begin
      state_next   = state_reg;
      ir_next      = ir_reg;
      fault_next   = fault_reg;
      step_next    = step_reg;
      mem_cnt_next = mem_cnt_reg;
      halt_next    = halt_reg;
      retired_next = retired_reg + {{(CNT_W-1){1'b0}}, retire};

      if (run_rise || ((state_reg == ST_IDLE) && step_i))
         halt_next = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (!fault_reg && (step_i || run_rise || (run_i && !halt_reg))) begin
               state_next = ST_FETCH;
               step_next  = step_i;
            end
         end
         ST_FETCH: begin
            if (imem_ack_i) begin
               ir_next    = instr_i;
               state_next = ST_DECODE;
            end
         end
         ST_DECODE: state_next = ST_EXEC;
         ST_EXEC: begin
            if (is_load || is_store) begin
               state_next   = ST_MEM;
               mem_cnt_next = 8'd0;
            end else begin
               state_next = after_retire;
               if (is_halt)
                  halt_next = 1'b1;
            end
         end
         ST_MEM: begin
            if (dmem_ack_i) begin
               state_next = is_load ? ST_WB : after_retire;
            end else if (mem_cnt_reg >= MEM_LAST) begin
               fault_next = 1'b1;
               state_next = ST_IDLE;
            end else begin
               mem_cnt_next = mem_cnt_reg + 8'd1;
            end
         end
         ST_WB: state_next = after_retire;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         state_reg   <= ST_IDLE;
         ir_reg      <= 8'd0;
         retired_reg <= '0;
         fault_reg   <= 1'b0;
         run_q_reg   <= 1'b0;
         halt_reg    <= 1'b0;
         step_reg    <= 1'b0;
         mem_cnt_reg <= 8'd0;
      end else begin
         state_reg   <= state_next;
         ir_reg      <= ir_next;
         retired_reg <= retired_next;
         fault_reg   <= fault_next;
         run_q_reg   <= run_i;
         halt_reg    <= halt_next;
         step_reg    <= step_next;
         mem_cnt_reg <= mem_cnt_next;
      end
   end

   assign imem_req_o      = (state_reg == ST_FETCH);
   assign dmem_req_o      = (state_reg == ST_MEM);
   assign dmem_we_o       = (state_reg == ST_MEM) && is_store;
   assign pc_load_o       = (state_reg == ST_EXEC) && is_jump && !is_halt;
   assign pc_inc_o        = ((state_reg == ST_EXEC) && is_arith) ||
                            ((state_reg == ST_MEM) && is_store && dmem_ack_i) ||
                            (state_reg == ST_WB);
   assign reg_write_o     = ((state_reg == ST_EXEC) && (is_add || is_sub)) ||
                            (state_reg == ST_WB);
   assign mem_to_reg_o    = (state_reg == ST_WB);
   assign alu_negate_o    = steer_en && is_sub;
   assign imm_sel_o       = steer_en && !is_arith;
   assign pc_sel_o        = steer_en && is_jump;
   assign reg_num_shift_o = steer_en && (is_load || is_store);

   assign ir_o      = ir_reg;
   assign halted_o  = (state_reg == ST_IDLE);
   assign fault_o   = fault_reg;
   assign state_o   = state_reg;
   assign retired_o = retired_reg;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer; inputs change 2ns after
// each rising edge and outputs are sampled before the next edge.
module tb_cpu_sequencer;

   logic        clk = 1'b0;
   logic        areset;
   logic        run_i, step_i, imem_ack_i, dmem_ack_i;
   logic [7:0]  instr_i;
   logic        imem_req_o, pc_inc_o, pc_load_o, reg_write_o, mem_to_reg_o;
   logic        alu_negate_o, imm_sel_o, pc_sel_o, reg_num_shift_o;
   logic        dmem_req_o, dmem_we_o, halted_o, fault_o;
   logic [7:0]  ir_o;
   logic [2:0]  state_o;
   logic [15:0] retired_o;

   int n_cmp = 0;
   int n_err = 0;

   cpu_sequencer #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
      .clk(clk), .areset(areset), .run_i(run_i), .step_i(step_i),
      .imem_req_o(imem_req_o), .imem_ack_i(imem_ack_i), .instr_i(instr_i),
      .ir_o(ir_o), .pc_inc_o(pc_inc_o), .pc_load_o(pc_load_o),
      .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o),
      .alu_negate_o(alu_negate_o), .imm_sel_o(imm_sel_o), .pc_sel_o(pc_sel_o),
      .reg_num_shift_o(reg_num_shift_o), .dmem_req_o(dmem_req_o),
      .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i), .halted_o(halted_o),
      .fault_o(fault_o), .state_o(state_o), .retired_o(retired_o)
   );

   always #5 clk = ~clk;

   logic [10:0] strobes;
   assign strobes = {imem_req_o, pc_inc_o, pc_load_o, reg_write_o, mem_to_reg_o,
                     alu_negate_o, imm_sel_o, pc_sel_o, reg_num_shift_o,
                     dmem_req_o, dmem_we_o};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   // Drives one fetch with a same-cycle ack; returns with the DUT in DECODE.
   task automatic fetch(input logic [7:0] ins);
      instr_i    = ins;
      imem_ack_i = 1'b1;
      tick();
      imem_ack_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      areset = 1'b0; run_i = 1'b0; step_i = 1'b0;
      imem_ack_i = 1'b0; dmem_ack_i = 1'b0; instr_i = 8'h00;
      tick(); tick();
      #1;
      check("rst_halted", 32'(halted_o), 32'd1);
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_retired", 32'(retired_o), 32'd0);
      check("rst_fault", 32'(fault_o), 32'd0);
      check("rst_strobes", 32'(strobes), 32'd0);
      check("rst_ir", 32'(ir_o), 32'd0);
      areset = 1'b1;
      tick();
      check("idle_no_run", 32'(state_o), 32'd0);

      // ADD 0xD4 in run mode
      run_i = 1'b1;
      tick();
      check("add_fetch_state", 32'(state_o), 32'd1);
      check("add_imem_req", 32'(imem_req_o), 32'd1);
      fetch(8'hD4);
      check("add_decode_state", 32'(state_o), 32'd2);
      check("add_ir", 32'(ir_o), 32'hD4);
      check("add_decode_steer", 32'({imm_sel_o, pc_sel_o, alu_negate_o, reg_num_shift_o}), 32'd0);
      tick();
      check("add_exec_state", 32'(state_o), 32'd3);
      check("add_exec_strobes", 32'({reg_write_o, pc_inc_o, pc_load_o, mem_to_reg_o}), 32'b1100);
      tick();
      check("add_retired", 32'(retired_o), 32'd1);
      check("add_next_fetch", 32'(state_o), 32'd1);
      $display("txn ADD  instr=d4 retired=%0d", retired_o);

      // LOAD 0x45 with dmem ack on the 4th MEM cycle
      fetch(8'h45);
      tick();
      check("ld_exec_state", 32'(state_o), 32'd3);
      check("ld_exec_steer", 32'({imm_sel_o, reg_num_shift_o, pc_sel_o}), 32'b110);
      check("ld_exec_nopc", 32'({pc_inc_o, pc_load_o, reg_write_o}), 32'd0);
      tick();
      cnt = 0;
      while (state_o == 3'd4 && cnt < 20) begin
         dmem_ack_i = (cnt == 3);
         #1;
         check("ld_mem_req", 32'(dmem_req_o), 32'd1);
         check("ld_mem_we", 32'(dmem_we_o), 32'd0);
         cnt++;
         tick();
      end
      dmem_ack_i = 1'b0;
      check("ld_mem_cycles", 32'(cnt), 32'd4);
      check("ld_wb_state", 32'(state_o), 32'd5);
      check("ld_wb_strobes", 32'({reg_write_o, mem_to_reg_o, pc_inc_o, dmem_req_o}), 32'b1110);
      tick();
      check("ld_retired", 32'(retired_o), 32'd2);
      $display("txn LOAD instr=45 mem_cycles=%0d retired=%0d", cnt, retired_o);

      // JUMP 0x3E (-2)
      fetch(8'h3E);
      check("jmp_decode_steer", 32'({pc_sel_o, imm_sel_o}), 32'b11);
      tick();
      check("jmp_exec", 32'({pc_load_o, pc_inc_o, pc_sel_o, imm_sel_o, reg_write_o}), 32'b10110);
      tick();
      check("jmp_retired", 32'(retired_o), 32'd3);
      check("jmp_next_fetch", 32'(state_o), 32'd1);
      $display("txn JMP  instr=3e retired=%0d", retired_o);

      // Halt jump 0x00 with run held high
      fetch(8'h00);
      tick();
      check("halt_exec_pc", 32'({pc_load_o, pc_inc_o}), 32'd0);
      tick();
      check("halt_state", 32'(state_o), 32'd0);
      check("halt_halted", 32'(halted_o), 32'd1);
      check("halt_retired", 32'(retired_o), 32'd4);
      tick();
      check("halt_stays", 32'(state_o), 32'd0);
      run_i = 1'b0;
      tick();
      run_i = 1'b1;
      tick();
      check("resume_fetch", 32'(state_o), 32'd1);
      $display("txn HALT instr=00 retired=%0d", retired_o);

      // NOP 0xC0 while run drops mid-instruction
      run_i = 1'b0;
      fetch(8'hC0);
      tick();
      check("nop_exec", 32'({pc_inc_o, reg_write_o, alu_negate_o}), 32'b100);
      tick();
      check("nop_retired", 32'(retired_o), 32'd5);
      check("nop_to_idle", 32'(state_o), 32'd0);
      $display("txn NOP  instr=c0 retired=%0d", retired_o);

      // Single step SUB 0xE9, with an ignored second step in FETCH
      step_i = 1'b1;
      tick();
      step_i = 1'b0;
      check("step_fetch", 32'(state_o), 32'd1);
      step_i = 1'b1;
      tick();
      step_i = 1'b0;
      check("step2_ignored", 32'(state_o), 32'd1);
      fetch(8'hE9);
      check("sub_decode_neg", 32'(alu_negate_o), 32'd1);
      tick();
      check("sub_exec", 32'({reg_write_o, pc_inc_o, alu_negate_o}), 32'b111);
      tick();
      check("sub_idle", 32'(state_o), 32'd0);
      check("sub_retired", 32'(retired_o), 32'd6);
      tick();
      check("sub_single", 32'(state_o), 32'd0);
      $display("txn SUB  instr=e9 retired=%0d", retired_o);

      // Store 0x86 with no ack: memory timeout fault
      step_i = 1'b1;
      tick();
      step_i = 1'b0;
      fetch(8'h86);
      tick();
      tick();
      cnt = 0;
      while (state_o == 3'd4 && cnt < 40) begin
         check("st_mem_req_we", 32'({dmem_req_o, dmem_we_o, pc_inc_o}), 32'b110);
         cnt++;
         tick();
      end
      check("st_timeout_cycles", 32'(cnt), 32'd15);
      check("st_fault", 32'(fault_o), 32'd1);
      check("st_fault_idle", 32'(state_o), 32'd0);
      check("st_no_retire", 32'(retired_o), 32'd6);
      dmem_ack_i = 1'b1;
      tick();
      dmem_ack_i = 1'b0;
      run_i = 1'b1;
      step_i = 1'b1;
      tick();
      step_i = 1'b0;
      tick();
      check("fault_sticky_state", 32'(state_o), 32'd0);
      check("fault_sticky_flag", 32'(fault_o), 32'd1);
      check("fault_sticky_ret", 32'(retired_o), 32'd6);
      $display("txn STORE instr=86 timeout_cycles=%0d fault=%0d", cnt, fault_o);

      // Reset clears the fault; reset asserted mid-MEM drops dmem_req at once
      run_i = 1'b0;
      areset = 1'b0;
      tick();
      check("rst2_fault", 32'(fault_o), 32'd0);
      check("rst2_retired", 32'(retired_o), 32'd0);
      areset = 1'b1;
      run_i = 1'b1;
      tick();
      fetch(8'h45);
      tick();
      tick();
      check("rst_mem_req_before", 32'(dmem_req_o), 32'd1);
      areset = 1'b0;
      #1;
      check("rst_mem_req_async", 32'(dmem_req_o), 32'd0);
      check("rst_mem_state_async", 32'(state_o), 32'd0);
      $display("txn ASYNC_RST during MEM dmem_req=%0d", dmem_req_o);
      run_i = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control sequencer for the 8-bit CPU datapath (PC, register file, ALU, sign extender, data memory).
- Replaces single-cycle combinational decode. Fetches each instruction over a request/acknowledge handshake and holds it in an internal IR.
- Issues per-state datapath strobes, waits on data-memory acknowledge, and supports run, single-step, halt and a memory-timeout fault.

Parameters:
MEM_TIMEOUT, 15, max cycles spent in MEM without dmem_ack_i before a fault (1..255)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock, all state updates on rising edge
areset  in  1  asynchronous active-low reset; 0 forces reset state immediately
run_i  in  1  level; 1 = execute continuously
step_i  in  1  one-cycle pulse; execute exactly one instruction while halted
imem_req_o  out  1  instruction fetch request
imem_ack_i  in  1  instruction valid on instr_i this cycle
instr_i  in  8  instruction byte
ir_o  out  8  latched instruction (drives datapath selectors/immediate)
pc_inc_o  out  1  PC <= PC+1 this edge
pc_load_o  out  1  PC <= ALU result (jump target) this edge
reg_write_o  out  1  register file write enable
mem_to_reg_o  out  1  register write data from dmem read data
alu_negate_o  out  1  ALU subtracts
imm_sel_o  out  1  ALU A operand = sign-extended immediate
pc_sel_o  out  1  ALU B operand = PC
reg_num_shift_o  out  1  register selectors use ir[5:4]/ir[3:2]
dmem_req_o  out  1  data memory access request
dmem_we_o  out  1  data memory write, qualified by dmem_req_o
dmem_ack_i  in  1  data memory access complete
halted_o  out  1  sequencer in IDLE
fault_o  out  1  sticky memory-timeout fault
state_o  out  3  current state encoding
retired_o  out  CNT_W  retired-instruction count

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
- Reset (areset=0, asynchronous):
  - State IDLE; IR=0; retired_o=0; fault_o=0; halted_o=1.
  - All strobes and requests 0; internal run-edge register cleared.
- Decode of IR (mode=ir[7:6], op=ir[5:4]):
  - 00 jump, offset ir[5:0].
  - 01 load: rt=rs[off].
  - 10 store: rd[off]=rs.
  - 11 arith: op 01 ADD, op 10 SUB, op 00/11 NOP.
- Steering outputs are valid from DECODE through end of instruction, and 0 in IDLE/FETCH:
  - jump: imm_sel=1, pc_sel=1.
  - load/store: imm_sel=1, reg_num_shift=1.
  - arith: all 0, except alu_negate=1 for SUB.
- IDLE:
  - Leave to FETCH on step_i=1, or on a rising edge of run_i, or when run_i=1 and no halt-jump latch is set.
  - Never leave while fault_o=1.
- FETCH:
  - imem_req_o=1 until imem_ack_i.
  - On the ack cycle, IR<=instr_i, then go to DECODE. No fetch timeout.
- DECODE: one cycle, then EXEC.
- EXEC:
  - Jump with offset≠0: pc_load_o=1, retire.
  - Jump with offset 0 (halt): no PC change; set halt latch; retire to IDLE regardless of run_i. The latch clears on the next rising edge of run_i or on step_i.
  - ADD/SUB: reg_write_o=1, pc_inc_o=1, retire.
  - NOP: pc_inc_o=1, retire.
  - Load/store: go to MEM.
- MEM:
  - dmem_req_o=1; dmem_we_o=1 for store. Wait counter starts at 0 on entry.
  - On dmem_ack_i: store sets pc_inc_o=1 and retires; load goes to WB.
  - If the counter reaches MEM_TIMEOUT with no ack: fault_o<=1, go to IDLE, no retire, no PC change.
- WB: reg_write_o=1, mem_to_reg_o=1, pc_inc_o=1, retire.
- Retire:
  - retired_o increments, wrapping at 2^CNT_W.
  - Next state is FETCH if run_i=1 and no step is in progress; otherwise IDLE.
  - A step from IDLE with run_i=0 executes one instruction then returns to IDLE.
- Latency with same-cycle acks:
  - Jump, arith and NOP: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- At most one of pc_inc_o/pc_load_o is 1 per cycle; the strobes are 1-cycle pulses.
- run_i dropping mid-instruction: the current instruction completes, then the sequencer goes to IDLE.
- step_i while not IDLE is ignored.
- A late ack after a timeout is ignored.
- A reset asserted mid-MEM drops dmem_req_o the same instant (asynchronous).

Test Plan:
- Reset → halted_o=1, state_o=0, retired_o=0, all strobes 0; run_i=1 with same-cycle acks on ADD (0xD4) → states 1,2,3, then reg_write_o+pc_inc_o pulse in EXEC, retired_o=1.
- Load 0x45 with dmem_ack_i delayed 3 cycles → dmem_req_o high 4 cycles, dmem_we_o=0; WB asserts reg_write_o, mem_to_reg_o, pc_inc_o; 5+3 cycles total.
- Store 0x86 with no ack, MEM_TIMEOUT=15 → fault_o=1 after 15 MEM cycles, state IDLE, retired_o unchanged; run_i/step_i have no effect until reset.
- Jump 0x3E (−2) → pc_load_o=1, pc_sel_o=1, imm_sel_o=1 in EXEC; jump 0x00 with run_i=1 → IDLE, halted_o=1; toggle run_i 0→1 resumes fetch.
- run_i=0, step_i pulse with SUB 0xE9 → exactly one instruction, alu_negate_o=1, back to IDLE, retired_o+1; second step_i during FETCH ignored.
